// File: rtl/tx_link_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_link_arbiter_pkg
// Shared definitions for the Tx link arbiter: default parameter values, the
// arbiter FSM state encoding and a small modular-increment helper used by the
// round-robin picker.
// -----------------------------------------------------------------------------
package tx_link_arbiter_pkg;

  // Defaults shared with the rx_receiver / tx_serializer side of the link.
  localparam int N_REQ_DEF      = 4;
  localparam int ID_W_DEF       = 2;
  localparam int PAYLOAD_W_DEF  = 128;
  localparam int IFG_CYCLES_DEF = 16;
  localparam int WD_CYCLES_DEF  = 2 ** 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } arb_state_e;

  // (base + off) mod modulus, for base < modulus and off <= modulus.
  function automatic int wrap_add(input int base, input int off, input int modulus);
    int sum;
    sum = base + off;
    if (sum >= modulus) sum = sum - modulus;
    return sum;
  endfunction

endpackage

// File: rtl/tx_link_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// tx_link_arbiter_rr_picker
// Purely combinational round-robin find-first. Scans req starting at
// last_idx+1 and wrapping modulo N_REQ; last_idx itself is scanned last, so a
// requester that was just served only wins again when nobody else is pending.
//
// Ports
//   req       in   N_REQ           pending requests
//   last_idx  in   $clog2(N_REQ)   most recently granted requester
//   valid     out  1               at least one request pending
//   idx       out  $clog2(N_REQ)   winning requester (last_idx when !valid)
// -----------------------------------------------------------------------------
module tx_link_arbiter_rr_picker
  import tx_link_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_idx,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    valid = 1'b0;
    idx   = last_idx;
    cand  = last_idx;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'(wrap_add(int'(last_idx), k, N_REQ));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tx_link_arbiter.sv
// -----------------------------------------------------------------------------
// tx_link_arbiter
// Shares one serial Tx line between N_REQ local packet sources. A round-robin
// pick latches the winner's dest/payload plus my_id, pulses grant, then runs a
// single tx_start / tx_busy / tx_done handshake with the serializer. After each
// frame an inter-frame gap of IFG_CYCLES idle clocks lets the far-end receiver
// re-synchronise before the next grant.
//
// Optional feature: define TX_ARB_WATCHDOG_EN to add a frame watchdog. A frame
// still waiting for the serializer after WD_CYCLES clocks is abandoned (no
// re-grant), err_timeout is set sticky until reset and the arbiter enters the
// gap. Without the macro the wait states wait forever and err_timeout is 0.
//
// Ports
//   clk          in   1                system clock
//   rst_n        in   1                asynchronous active-low reset
//   my_id        in   ID_W             local node ID, latched onto tx_src_id
//   req          in   N_REQ            per-requester frame pending
//   req_dest     in   N_REQ*ID_W       packed dest IDs, slice i = requester i
//   req_payload  in   N_REQ*PAYLOAD_W  packed payloads, slice i = requester i
//   grant        out  N_REQ            one-hot 1-cycle pulse, data latched
//   tx_start     out  1                1-cycle start pulse to serializer
//   tx_dest_id   out  ID_W             latched dest
//   tx_src_id    out  ID_W             latched my_id
//   tx_payload   out  PAYLOAD_W        latched payload
//   tx_busy      in   1                serializer shifting a frame
//   tx_done      in   1                serializer 1-cycle frame-complete pulse
//   arb_busy     out  1                high in every state except IDLE
//   active_idx   out  $clog2(N_REQ)    current / last granted requester
//   err_timeout  out  1                sticky watchdog flag
// -----------------------------------------------------------------------------
module tx_link_arbiter
  import tx_link_arbiter_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int PAYLOAD_W  = PAYLOAD_W_DEF,
  parameter int IFG_CYCLES = IFG_CYCLES_DEF,
  parameter int WD_CYCLES  = WD_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ID_W-1:0]            my_id,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ID_W-1:0]      req_dest,
  input  logic [N_REQ*PAYLOAD_W-1:0] req_payload,
  output logic [N_REQ-1:0]           grant,
  output logic                       tx_start,
  output logic [ID_W-1:0]            tx_dest_id,
  output logic [ID_W-1:0]            tx_src_id,
  output logic [PAYLOAD_W-1:0]       tx_payload,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       arb_busy,
  output logic [$clog2(N_REQ)-1:0]   active_idx,
  output logic                       err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  arb_state_e            state_q,    state_d;
  logic [N_REQ-1:0]      grant_q,    grant_d;
  logic                  tx_start_q, tx_start_d;
  logic [ID_W-1:0]       dest_q,     dest_d;
  logic [ID_W-1:0]       src_q,      src_d;
  logic [PAYLOAD_W-1:0]  payload_q,  payload_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [GAP_W-1:0]      gap_q,      gap_d;
  logic                  arb_busy_q, arb_busy_d;

`ifdef TX_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] wd_q,  wd_d;
  logic            err_q, err_d;
`else
  // The watchdog limit only matters when the watchdog is built in.
  logic unused_wd_cfg;
  assign unused_wd_cfg = (WD_CYCLES > 0);
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick and slice selection of the winner's data
  // ---------------------------------------------------------------------------
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [ID_W-1:0]      pick_dest;
  logic [PAYLOAD_W-1:0] pick_payload;

  tx_link_arbiter_rr_picker #(
    .N_REQ (N_REQ)
  ) u_rr_picker (
    .req      (req),
    .last_idx (idx_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    pick_dest    = '0;
    pick_payload = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_dest    = req_dest[i*ID_W +: ID_W];
        pick_payload = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    dest_d     = dest_q;
    src_d      = src_q;
    payload_d  = payload_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
`ifdef TX_ARB_WATCHDOG_EN
    wd_d       = '0;
    err_d      = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // The frame's data is captured on the pick edge only; the requester
        // is free to drop or change its inputs from the grant cycle onwards.
        if (pick_valid) begin
          state_d   = ST_GRANT;
          grant_d   = ONE_HOT0 << pick_idx;
          idx_d     = pick_idx;
          dest_d    = pick_dest;
          src_d     = my_id;
          payload_d = pick_payload;
        end
      end

      ST_GRANT: begin
        state_d    = ST_START;
        tx_start_d = 1'b1;
      end

      ST_START: state_d = ST_WAIT_BUSY;

      ST_WAIT_BUSY: begin
        // A serializer that finishes before busy is ever observed still
        // completes the frame.
        if (tx_done) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end

      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef TX_ARB_WATCHDOG_EN
    // Counter is cleared outside the wait states, so it measures the time
    // since the frame left START. A tx_done on the expiry cycle wins.
    if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
      wd_d = wd_q + 1'b1;
      if (!tx_done && wd_q == WD_LAST) begin
        err_d   = 1'b1;
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
    end
`endif

    arb_busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // NOTE: the wide payload flops are reset too, so a reset mid-frame leaves
  // no stale frame data visible on the serializer interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      dest_q     <= '0;
      src_q      <= '0;
      payload_q  <= '0;
      idx_q      <= IDX_LAST;
      gap_q      <= '0;
      arb_busy_q <= 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      payload_q  <= payload_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      arb_busy_q <= arb_busy_d;
`ifdef TX_ARB_WATCHDOG_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant      = grant_q;
  assign tx_start   = tx_start_q;
  assign tx_dest_id = dest_q;
  assign tx_src_id  = src_q;
  assign tx_payload = payload_q;
  assign arb_busy   = arb_busy_q;
  assign active_idx = idx_q;
`ifdef TX_ARB_WATCHDOG_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tx_link_arbiter.sv
`timescale 1ns/1ps
module tb_tx_link_arbiter;

  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int PAYLOAD_W  = 128;
  localparam int IFG_CYCLES = 16;
  localparam int WD_CYCLES  = 100;
  // done cycle -> GAP (IFG_CYCLES cycles) -> one IDLE cycle -> grant cycle
  localparam int DONE_TO_GRANT = IFG_CYCLES + 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [ID_W-1:0]            my_id;
  logic [N_REQ-1:0]           req;
  logic [N_REQ*ID_W-1:0]      req_dest;
  logic [N_REQ*PAYLOAD_W-1:0] req_payload;
  logic [N_REQ-1:0]           grant;
  logic                       tx_start;
  logic [ID_W-1:0]            tx_dest_id;
  logic [ID_W-1:0]            tx_src_id;
  logic [PAYLOAD_W-1:0]       tx_payload;
  logic                       tx_busy;
  logic                       tx_done;
  logic                       arb_busy;
  logic [1:0]                 active_idx;
  logic                       err_timeout;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [PAYLOAD_W-1:0] pay [N_REQ];
  logic [ID_W-1:0]      dst [N_REQ];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_link_arbiter #(
    .N_REQ      (N_REQ),
    .ID_W       (ID_W),
    .PAYLOAD_W  (PAYLOAD_W),
    .IFG_CYCLES (IFG_CYCLES),
    .WD_CYCLES  (WD_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .my_id       (my_id),
    .req         (req),
    .req_dest    (req_dest),
    .req_payload (req_payload),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_dest_id  (tx_dest_id),
    .tx_src_id   (tx_src_id),
    .tx_payload  (tx_payload),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .arb_busy    (arb_busy),
    .active_idx  (active_idx),
    .err_timeout (err_timeout)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic pack_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      req_dest[i*ID_W +: ID_W]              = dst[i];
      req_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay[i];
    end
  endtask

  task automatic wait_grant(input int budget, output logic [N_REQ-1:0] g,
                            output int t, output bit timed_out);
    timed_out = 1'b1;
    g = '0;
    t = 0;
    for (int i = 0; i < budget && timed_out; i++) begin
      @(negedge clk);
      if (grant !== '0) begin
        g = grant;
        t = cyc;
        timed_out = 1'b0;
      end
    end
  endtask

  // Serializer model, entered at the negedge of the grant cycle.
  task automatic serve(input int busy_cycles, output logic start_seen,
                       output logic start_next, output int done_t);
    @(negedge clk);
    start_seen = tx_start;
    @(negedge clk);
    start_next = tx_start;
    if (busy_cycles > 0) begin
      tx_busy = 1'b1;
      repeat (busy_cycles) @(negedge clk);
      tx_busy = 1'b0;
    end
    tx_done = 1'b1;
    done_t  = cyc;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic settle();
    repeat (IFG_CYCLES + 4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = '1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({grant, tx_start, arb_busy, err_timeout} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: grant/start/busy/err=%b required 0000000",
               {grant, tx_start, arb_busy, err_timeout});
    end
    vectors++;
    if ({tx_dest_id, tx_src_id, tx_payload} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: dest=%h src=%h payload=%h required all zero",
               tx_dest_id, tx_src_id, tx_payload);
    end
    vectors++;
    if (active_idx !== 2'd3) begin
      miscompares++;
      $display("FAIL reset_active_idx: got %0d required 3", active_idx);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N_REQ-1:0] g, exp_g;
    int t, rel_t, done_t;
    bit to;
    logic s0, s1;
    my_id = 2'b10;
    rel_t = cyc;
    rst_n = 1'b1;
    done_t = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(60, g, t, to);
      exp_g = 4'b0001 << order[k];
      vectors++;
      if (to || g !== exp_g) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got %b timeout=%0d required %b", k, g, to, exp_g);
      end
      vectors++;
      if (active_idx !== 2'(order[k]) || tx_dest_id !== dst[order[k]] ||
          tx_payload !== pay[order[k]] || tx_src_id !== my_id) begin
        miscompares++;
        $display("FAIL rr_data[%0d]: idx=%0d dest=%h src=%h payload=%h required idx=%0d dest=%h src=%h payload=%h",
                 k, active_idx, tx_dest_id, tx_src_id, tx_payload,
                 order[k], dst[order[k]], my_id, pay[order[k]]);
      end
      vectors++;
      if (k == 0 && t - rel_t != 1) begin
        miscompares++;
        $display("FAIL rr_first_latency: got %0d cycles required 1", t - rel_t);
      end else if (k > 0 && t - done_t != DONE_TO_GRANT) begin
        miscompares++;
        $display("FAIL rr_gap[%0d]: done->grant %0d cycles required %0d",
                 k, t - done_t, DONE_TO_GRANT);
      end
      serve(39, s0, s1, done_t);
      vectors++;
      if (s0 !== 1'b1 || s1 !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_start_pulse[%0d]: start=%b next=%b required 1 then 0", k, s0, s1);
      end
    end
    req = '0;
    settle();
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] g;
    int t, drive_t, done_t;
    bit to;
    logic s0, s1;
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: arb_busy=%b required 0", arb_busy);
    end
    my_id   = 2'b01;
    req     = 4'b0100;
    drive_t = cyc;
    wait_grant(8, g, t, to);
    req = '0;
    vectors++;
    if (to || g !== 4'b0100 || t - drive_t != 1) begin
      miscompares++;
      $display("FAIL single_grant: got %b after %0d cycles timeout=%0d required 0100 after 1",
               g, t - drive_t, to);
    end
    vectors++;
    if (tx_payload[7:0] !== 8'hA5 || tx_src_id !== 2'b01 || tx_dest_id !== 2'd1) begin
      miscompares++;
      $display("FAIL single_data: payload[7:0]=%h src=%h dest=%h required a5 1 1",
               tx_payload[7:0], tx_src_id, tx_dest_id);
    end
    serve(10, s0, s1, done_t);
    vectors++;
    if (s0 !== 1'b1 || s1 !== 1'b0 || tx_payload !== pay[2]) begin
      miscompares++;
      $display("FAIL single_start: start=%b next=%b payload=%h required 1 0 %h",
               s0, s1, tx_payload, pay[2]);
    end
    settle();
    // A stray tx_done while idle must not wake the arbiter.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (arb_busy !== 1'b0 || grant !== '0 || tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_done_ignored: busy=%b grant=%b start=%b required 0 0000 0",
               arb_busy, grant, tx_start);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] g;
    int t, done_t;
    bit to;
    logic s0, s1;
    req = 4'b0010;
    done_t = 0;
    for (int k = 0; k < 3; k++) begin
      wait_grant(60, g, t, to);
      vectors++;
      if (to || g !== 4'b0010) begin
        miscompares++;
        $display("FAIL b2b_grant[%0d]: got %b timeout=%0d required 0010", k, g, to);
      end
      if (k > 0) begin
        vectors++;
        if (t - done_t != DONE_TO_GRANT) begin
          miscompares++;
          $display("FAIL b2b_gap[%0d]: done->grant %0d cycles required %0d",
                   k, t - done_t, DONE_TO_GRANT);
        end
      end
      // Second frame completes without tx_busy ever rising.
      serve((k == 1) ? 0 : 20, s0, s1, done_t);
    end
    req = '0;
    settle();
  endtask

  task automatic test_drop();
    logic [N_REQ-1:0] g;
    int t, done_t;
    bit to;
    logic s0, s1;
    req = 4'b1000;
    wait_grant(8, g, t, to);
    req = '0;
    req_payload[3*PAYLOAD_W +: PAYLOAD_W] = ~pay[3];
    req_dest[3*ID_W +: ID_W]              = ~dst[3];
    vectors++;
    if (to || g !== 4'b1000) begin
      miscompares++;
      $display("FAIL drop_grant: got %b timeout=%0d required 1000", g, to);
    end
    serve(12, s0, s1, done_t);
    vectors++;
    if (s0 !== 1'b1 || tx_payload !== pay[3] || tx_dest_id !== dst[3]) begin
      miscompares++;
      $display("FAIL drop_frame: start=%b payload=%h dest=%h required 1 %h %h",
               s0, tx_payload, tx_dest_id, pay[3], dst[3]);
    end
    wait_grant(40, g, t, to);
    vectors++;
    if (!to) begin
      miscompares++;
      $display("FAIL drop_single_grant: extra grant %b required none", g);
    end
    pack_inputs();
  endtask

  task automatic test_reset_mid_frame();
    logic [N_REQ-1:0] g;
    int t, done_t;
    bit to;
    logic s0, s1;
    req = 4'b0001;
    wait_grant(8, g, t, to);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    vectors++;
    if (arb_busy !== 1'b1 || tx_payload !== pay[0]) begin
      miscompares++;
      $display("FAIL midrst_pre: busy=%b payload=%h required 1 %h", arb_busy, tx_payload, pay[0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({grant, tx_start, arb_busy, tx_dest_id, tx_src_id, tx_payload} !== '0 ||
        active_idx !== 2'd3) begin
      miscompares++;
      $display("FAIL midrst_outputs: grant=%b start=%b busy=%b payload=%h idx=%0d required zeros idx=3",
               grant, tx_start, arb_busy, tx_payload, active_idx);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0010;
    wait_grant(4, g, t, to);
    req = '0;
    vectors++;
    if (to || g !== 4'b0010 || tx_payload !== pay[1]) begin
      miscompares++;
      $display("FAIL midrst_recover: grant=%b timeout=%0d payload=%h required 0010 %h",
               g, to, tx_payload, pay[1]);
    end
    serve(5, s0, s1, done_t);
    settle();
  endtask

`ifdef TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    logic [N_REQ-1:0] g;
    int t, s, e;
    bit to;
    req = 4'b0100;
    wait_grant(8, g, t, to);
    req = '0;
    @(negedge clk);
    s = cyc;
    to = 1'b1;
    e = 0;
    for (int i = 0; i < 300 && to; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin
        to = 1'b0;
        e  = cyc;
      end
    end
    vectors++;
    if (to || e - s != WD_CYCLES + 1) begin
      miscompares++;
      $display("FAIL wd_timeout: err after %0d cycles timeout=%0d required %0d",
               e - s, to, WD_CYCLES + 1);
    end
    req = 4'b1000;
    wait_grant(40, g, t, to);
    req = '0;
    vectors++;
    if (to || g !== 4'b1000 || t - e != IFG_CYCLES + 1 || err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_recover: grant=%b after %0d timeout=%0d err=%b required 1000 after %0d err=1",
               g, t - e, to, err_timeout, IFG_CYCLES + 1);
    end
  endtask
`else
  task automatic test_no_watchdog();
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL no_wd_err: err_timeout=%b required 0", err_timeout);
    end
  endtask
`endif

  initial begin
    pay[0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA0;
    pay[1] = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_69A1;
    pay[2] = 128'h1234_5678_9ABC_DEF0_CAFE_F00D_DEAD_BEA5;
    pay[3] = 128'hA5A5_5A5A_0000_FFFF_1357_9BDF_2468_ACA3;
    dst[0] = 2'd2;
    dst[1] = 2'd3;
    dst[2] = 2'd1;
    dst[3] = 2'd0;
    rst_n   = 1'b0;
    my_id   = 2'b00;
    req     = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    pack_inputs();

    test_reset();
    test_round_robin();
    test_single();
    test_back_to_back();
    test_drop();
    test_reset_mid_frame();
`ifdef TX_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
